// File: rtl/alu_pkg.sv
// Shared definitions for the sequential 8-bit ALU: opcodes, FSM states, flag bit positions.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 8;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SHL = 3'b101;
  localparam logic [2:0] ALU_SHR = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    MUL  = 2'b10
  } alu_state_e;

  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_V = 0;

  function automatic logic [3:0] pack_flags(input logic c, input logic z, input logic n,
                                            input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_shift_add.sv
// Unsigned shift-add multiplier: one partial product per clock, done pulses (combinationally)
// during the last iteration so the caller registers product_o on that same edge.
module alu_mul_shift_add
  import alu_pkg::*;
#(
  parameter int unsigned Width   = 8,
  parameter int unsigned MulIter = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [Width-1:0]     a_i,
  input  logic [Width-1:0]     b_i,
  output logic                 done_o,
  output logic [2*Width-1:0]   product_o
);

  localparam int unsigned CntW = (MulIter > 1) ? $clog2(MulIter) : 1;

  logic                 active_q, active_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*Width-1:0]   acc_q, acc_d;
  logic [2*Width-1:0]   mcand_q, mcand_d;
  logic [Width-1:0]     mplier_q, mplier_d;
  logic [2*Width-1:0]   step_acc;

  always_comb begin
    active_d  = active_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    done_o    = 1'b0;
    step_acc  = acc_q + (mplier_q[0] ? mcand_q : '0);

    if (start_i && !active_q) begin
      active_d = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = {{Width{1'b0}}, a_i};
      mplier_d = b_i;
    end else if (active_q) begin
      acc_d    = step_acc;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CntW'(MulIter - 1)) begin
        done_o   = 1'b1;
        active_d = 1'b0;
        cnt_d    = '0;
      end
    end
  end

  // Final sum including the last partial product.
  assign product_o = step_acc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/alu_seq_8bit.sv
// Sequential ALU stage behind mux_1: one op per start/done handshake, status flags {C,Z,N,V}.
// Single-cycle ops go through EXEC; MUL hands off to the shift-add sub-module.
module alu_seq_8bit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MUL_ITER = 8
) (
  input  logic             alu_clk,
  input  logic             alu_rst,
  input  logic             alu_start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic             alu_comp_carry_in,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] alu_result_hi,
  output logic             alu_busy,
  output logic             alu_done,
  output logic [3:0]       alu_flags
);

  alu_state_e       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;

  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;

  assign mul_start = (state_q == IDLE) && alu_start && (alu_op == ALU_MUL);

  alu_mul_shift_add #(
    .Width   (WIDTH),
    .MulIter (MUL_ITER)
  ) u_mul (
    .clk_i     (alu_clk),
    .rst_i     (alu_rst),
    .start_i   (mul_start),
    .a_i       (alu_a),
    .b_i       (alu_b),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  // Single-cycle datapath on the latched operands; b is already complemented for SUB.
  always_comb begin
    sum   = {1'b0, a_q} + {1'b0, b_q};
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (op_q)
      ALU_ADD: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
      end
      ALU_SUB: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH] | cin_q;
        res_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
      end
      ALU_AND: res = a_q & b_q;
      ALU_OR:  res = a_q | b_q;
      ALU_XOR: res = a_q ^ b_q;
      ALU_SHL: begin
        res   = a_q << 1;
        res_c = a_q[WIDTH-1];
      end
      ALU_SHR: begin
        res   = a_q >> 1;
        res_c = a_q[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (alu_start) begin
          op_d    = alu_op;
          a_d     = alu_a;
          b_d     = alu_b;
          cin_d   = alu_comp_carry_in;
          state_d = (alu_op == ALU_MUL) ? MUL : EXEC;
        end
      end
      EXEC: begin
        result_d    = res;
        result_hi_d = '0;
        flags_d     = pack_flags(res_c, res == '0, res[WIDTH-1], res_v);
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      MUL: begin
        if (mul_done) begin
          result_d    = mul_product[WIDTH-1:0];
          result_hi_d = mul_product[2*WIDTH-1:WIDTH];
          flags_d     = pack_flags(|mul_product[2*WIDTH-1:WIDTH], mul_product == '0,
                                   mul_product[2*WIDTH-1], 1'b0);
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge alu_clk) begin
    if (alu_rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
      done_q      <= done_d;
    end
  end

  assign alu_result    = result_q;
  assign alu_result_hi = result_hi_q;
  assign alu_flags     = flags_q;
  assign alu_done      = done_q;
  assign alu_busy      = (state_q != IDLE);

endmodule

// File: doc/alu_seq_8bit.md
Name: alu_seq_8bit

Overview:
- Sequential 8-bit ALU stage directly downstream of mux_1.
- Operand B arrives through mux_1: either the raw register value or the 2's-complemented value from the complement stage, together with that stage's carry.
- Executes one operation per start/done handshake and holds a 4-bit status register (C, Z, N, V).
- Single-cycle ops finish in 1 cycle; MUL runs an 8-iteration shift-add.

Parameters:
- WIDTH, 8, operand/result width; only 8 is supported.
- MUL_ITER, 8, shift-add iterations for MUL; must equal WIDTH.

Ports:
- alu_clk  input  1  system clock, rising edge.
- alu_rst  input  1  synchronous, active-high reset.
- alu_start  input  1  request; accepted only in IDLE.
- alu_op  input  3  opcode, sampled on accept.
- alu_a  input  8  operand A (from reg0), sampled on accept.
- alu_b  input  8  operand B (mux_1 output), sampled on accept.
- alu_comp_carry_in  input  1  complement-stage carry, sampled on accept.
- alu_result  output  8  result low byte.
- alu_result_hi  output  8  MUL high byte; 0 for all other ops.
- alu_busy  output  1  high in EXEC and MUL.
- alu_done  output  1  one-cycle pulse: result and flags valid.
- alu_flags  output  4  {C,Z,N,V} status register.

Behaviour:
- Clock/reset: one clock alu_clk; reset alu_rst is synchronous, active-high.
- Reset values: alu_result, alu_result_hi, alu_flags = 0; alu_busy = 0; alu_done = 0; state IDLE; iteration counter = 0.
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
- States and transitions:
  - IDLE, alu_start=1 → latch op, a, b, comp_carry_in. Go to EXEC for ops 000–110, MUL for 111.
  - EXEC → compute, register result and flags, pulse done, return to IDLE (1 edge).
  - MUL → each edge: if multiplier bit0 is set, add multiplicand to the 16-bit accumulator; shift multiplier right; shift multiplicand left; counter +1. On the edge where counter = 7, write result/result_hi and flags, pulse done, go to IDLE.
- Latency: accept on edge k. alu_done is high in the cycle after edge k+1 for EXEC ops, and after edge k+8 for MUL.
- Back-to-back: start may be high in the same cycle as done; it is accepted on the next edge.
- alu_start while busy is ignored, with no queuing.
- ADD: 9-bit sum a+b. C = sum[8]; V = (a7==b7)&&(r7!=a7).
- SUB: b is already 2's-complemented upstream. C = sum[8] | comp_carry_in (covers b=0 → no borrow). V uses the same formula on a and the presented b.
- AND/OR/XOR: C = 0, V = 0.
- SHL: C = a7, r = a<<1. SHR: C = a0, r = a>>1 (logical). V = 0 for both.
- MUL: 16-bit unsigned product. C = |hi; V = 0; Z = product==0; N = product[15].
- Other ops: Z = (r==0), N = r7.
- alu_flags and outputs change only on the done edge; otherwise they hold.
- alu_result_hi is cleared to 0 on any non-MUL completion.
- Reset mid-operation (EXEC or MUL): abort; no done pulse; all outputs return to reset values on that edge.
- Reset has priority over start in the same cycle.

Decomposition:
- Shared package alu_pkg:
  - opcode constants (ALU_ADD..ALU_MUL);
  - state encoding (IDLE, EXEC, MUL);
  - flag bit indices (FLAG_C=3, FLAG_Z=2, FLAG_N=1, FLAG_V=0).
- One natural sub-module: alu_mul_shift_add. It holds the 8-iteration multiplier datapath (accumulator, shift registers, counter) with its own start/done handshake to the top FSM.

Test Plan:
- Reset then ADD a=0x7F, b=0x01 → after edge k+1: done=1, result=0x80, flags C=0 Z=0 N=1 V=1; busy=1 for exactly one cycle.
- SUB with b=0x00 and comp_carry_in=1, a=0x05 → result=0x05, C=1, Z=0, N=0, V=0. Then a=0x05, b=0xFB (−5), comp_carry_in=0 → result=0x00, C=1, Z=1.
- MUL a=0xFF, b=0xFF → done exactly 8 cycles after accept; result_hi=0xFE, result=0x01, C=1. A second start issued at cycle 3 is ignored (only one done pulse).
- SHL a=0x81 → result=0x02, C=1. SHR a=0x01 → result=0x00, C=1, Z=1. AND a=0xF0, b=0x0F → result=0x00, Z=1, C=0; result_hi=0.
- Assert alu_rst at MUL iteration 4 → no done pulse, busy=0, all outputs 0. A new ADD 0x01+0x01 afterward → result=0x02 after one cycle.
- Start held high continuously with ADD → done pulses every 2 cycles; flags stay stable between pulses.
